// File: rtl/mul_unit.sv
// mul_unit: multi-cycle RV32M multiplier (MUL, MULH, MULHSU, MULHU).
// Radix-2 shift-add on operand magnitudes, one sign-fixup cycle, then a
// one-cycle done pulse with the selected half of the 2*XLEN product.
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [1:0]      op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_result;
    logic              r_done;
    logic              r_busy;
    logic              r_inReady;

    logic              w_negA;
    logic              w_negB;
    logic              w_negProd;
    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_accShifted;
    logic [2*XLEN-1:0] w_accFixed;
    logic [XLEN-1:0]   w_resultSel;
    logic              w_accept;
    logic              w_lastIter;

    // Operand sign handling at accept time: magnitudes plus the product sign.
    always_comb begin
        w_negA    = ((op == OP_MULH) || (op == OP_MULHSU)) && op_a[XLEN-1];
        w_negB    = (op == OP_MULH) && op_b[XLEN-1];
        w_negProd = 1'b0;
        if (op == OP_MULH) begin
            w_negProd = op_a[XLEN-1] ^ op_b[XLEN-1];
        end else if (op == OP_MULHSU) begin
            w_negProd = op_a[XLEN-1];
        end
        w_absA = w_negA ? (~op_a + {{(XLEN-1){1'b0}}, 1'b1}) : op_a;
        w_absB = w_negB ? (~op_b + {{(XLEN-1){1'b0}}, 1'b1}) : op_b;
    end

    // One shift-add step: add into the upper half with carry, then shift right.
    always_comb begin
        w_addend     = r_mplier[0] ? r_mcand : '0;
        w_sum        = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
        w_accShifted = {w_sum, r_acc[XLEN-1:1]};
        w_accFixed   = r_neg ? (~r_acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : r_acc;
        w_resultSel  = (r_op == OP_MUL) ? w_accFixed[XLEN-1:0]
                                        : w_accFixed[2*XLEN-1:XLEN];
        w_accept     = in_valid && r_inReady;
        w_lastIter   = (r_count == CW'(XLEN - 1));
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_inReady <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= op;
                        r_neg     <= w_negProd;
                        r_mcand   <= w_absA;
                        r_mplier  <= w_absB;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_state   <= CALC;
                        r_busy    <= 1'b1;
                        r_inReady <= 1'b0;
                    end
                end
                CALC: begin
                    r_acc    <= w_accShifted;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (w_lastIter) begin
                        r_state <= SIGN;
                    end
                end
                SIGN: begin
                    r_acc    <= w_accFixed;
                    r_result <= w_resultSel;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_inReady <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_inReady <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = r_inReady;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: randomized and directed checks of mul_unit against a
// 64-bit arithmetic reference model.
module tb_mul_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int passCount;
    int checkCount;

    mul_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: full 64-bit product of suitably extended operands.
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] o);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one op (caller is #1 after an edge with in_ready high), scramble
    // inputs after accept, and report result, latency and the following cycle.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         output logic [31:0] res, output int lat,
                         output logic readyAfter, output logic doneAfter);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        op = 2'($urandom);
        lat = -1;
        res = 'x;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        res = result;
        @(posedge clk);
        #1;
        readyAfter = in_ready;
        doneAfter = done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        op = '0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({in_ready, busy, done} !== 3'b100 || result !== 32'h0)
            $display("[TB] FAIL reset_state: ready/busy/done=%b result=%h, required 100 / 00000000",
                     {in_ready, busy, done}, result);
        else passCount++;
        // Reset and in_valid together: nothing is accepted.
        in_valid = 1'b1;
        op_a = 32'd9;
        op_b = 32'd9;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkCount++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL reset_wins: busy=%b in_ready=%b, required 0 / 1", busy, in_ready);
        else passCount++;
    endtask

    task automatic test_directed;
        logic [31:0] a [8] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b [8] = '{32'd6, 32'd5, 32'd5, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [1:0]  o [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00};
        logic [31:0] e [8] = '{32'h0000002A, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'h40000000,
                               32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
        logic [31:0] res;
        int lat;
        logic rdy;
        logic dn;
        for (int i = 0; i < 8; i++) begin
            runOp(a[i], b[i], o[i], res, lat, rdy, dn);
            checkCount++;
            if (res !== e[i] || res !== refMul(a[i], b[i], o[i]))
                $display("[TB] FAIL directed_%0d: result=%h, required %h", i, res, e[i]);
            else passCount++;
            if (i == 0) begin
                checkCount++;
                if (lat !== 33 || rdy !== 1'b1 || dn !== 1'b0)
                    $display("[TB] FAIL latency: edges=%0d ready_after=%b done_after=%b, required 33 / 1 / 0",
                             lat, rdy, dn);
                else passCount++;
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        logic [31:0] res;
        int lat;
        logic rdy;
        logic dn;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            o = 2'($urandom);
            if (i % 6 == 1) a = 32'h0;
            if (i % 6 == 2) b = 32'h80000000;
            if (i % 6 == 3) a = 32'h7FFFFFFF;
            runOp(a, b, o, res, lat, rdy, dn);
            checkCount++;
            if (res !== refMul(a, b, o) || lat !== 33 || rdy !== 1'b1 || dn !== 1'b0)
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: result=%h lat=%0d, required %h lat=33",
                         i, o, a, b, res, lat, refMul(a, b, o));
            else passCount++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] expQ [$];
        int acceptCyc [$];
        logic prevDone;
        int doneSeen;
        logic [31:0] expv;
        prevDone = 1'b0;
        doneSeen = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (done) begin
                doneSeen++;
                checkCount++;
                if (prevDone)
                    $display("[TB] FAIL done_twice: done high on consecutive cycles at %0d", cyc);
                else passCount++;
                expv = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEADBEEF;
                checkCount++;
                if (result !== expv)
                    $display("[TB] FAIL b2b_result: result=%h, required %h", result, expv);
                else passCount++;
            end
            prevDone = done;
            if (cyc >= 110) in_valid = 1'b0;
            op_a = $urandom;
            op_b = $urandom;
            op = 2'($urandom);
            if (in_ready && in_valid) begin
                expQ.push_back(refMul(op_a, op_b, op));
                acceptCyc.push_back(cyc);
                if (acceptCyc.size() > 1) begin
                    checkCount++;
                    if (acceptCyc[$] - acceptCyc[$-1] !== 35)
                        $display("[TB] FAIL issue_interval: %0d cycles, required 35",
                                 acceptCyc[$] - acceptCyc[$-1]);
                    else passCount++;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (40) begin
            if (done) begin
                doneSeen++;
                expv = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEADBEEF;
                checkCount++;
                if (result !== expv)
                    $display("[TB] FAIL b2b_drain: result=%h, required %h", result, expv);
                else passCount++;
            end
            @(posedge clk);
            #1;
        end
        checkCount++;
        if (acceptCyc.size() !== 4 || doneSeen !== 4)
            $display("[TB] FAIL b2b_count: accepts=%0d dones=%0d, required 4 / 4",
                     acceptCyc.size(), doneSeen);
        else passCount++;
    endtask

    task automatic test_reset_abort;
        logic [31:0] res;
        int lat;
        logic rdy;
        logic dn;
        int doneSeen;
        in_valid = 1'b1;
        op_a = 32'd7;
        op_b = 32'd6;
        op = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || done !== 1'b0)
            $display("[TB] FAIL abort_state: busy=%b ready=%b result=%h done=%b, required 0 1 00000000 0",
                     busy, in_ready, result, done);
        else passCount++;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkCount++;
        if (doneSeen !== 0)
            $display("[TB] FAIL abort_no_done: saw %0d done pulses, required 0", doneSeen);
        else passCount++;
        runOp(32'd3, 32'd4, 2'b00, res, lat, rdy, dn);
        checkCount++;
        if (res !== 32'h0000000C || lat !== 33)
            $display("[TB] FAIL after_abort: result=%h lat=%0d, required 0000000C lat=33", res, lat);
        else passCount++;
    endtask

    initial begin
        passCount = 0;
        checkCount = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
